// File: rtl/mem_bist_ctrl.sv
// March BIST initiator for the 16x16 single-port RAM (W0, R0, W1, R1).
// Define MEM_BIST_STOP_ON_FAIL_EN to end the run on the first mismatch.
module mem_bist_ctrl #(
   parameter int             DW      = 16,
   parameter int             AW      = 4,
   parameter logic [DW-1:0]  PATTERN = 16'hA5A5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic          done,
   output logic          fail,
   output logic [AW-1:0] fail_addr,
   output logic          fail_phase,
   output logic [4:0]    err_count
);

   typedef enum logic [2:0] {
      IDLE, W0, R0, R0_DRAIN, W1, R1, R1_DRAIN, DONE
   } state_t;

   localparam logic [AW-1:0] TOP = '1;
   localparam logic [AW-1:0] BOT = '0;

   state_t        state, state_n;
   logic [AW-1:0] addr_n;
   logic [DW-1:0] wdata_n;
   logic          we_n;
   logic          busy_n;
   logic          done_n;
   logic          fail_n;
   logic [AW-1:0] fail_addr_n;
   logic          fail_phase_n;
   logic [4:0]    err_n;

   // Read-check pipe: address issued this cycle is checked next edge.
   logic          pv, pv_n;
   logic [AW-1:0] pa, pa_n;
   logic          pp, pp_n;
   logic [DW-1:0] exp_data;
   logic          mism;

   assign exp_data = pp ? ~PATTERN : PATTERN;
   assign mism     = pv && (mem_rdata != exp_data);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_we     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         fail       <= 1'b0;
         fail_addr  <= '0;
         fail_phase <= 1'b0;
         err_count  <= '0;
         pv         <= 1'b0;
         pa         <= '0;
         pp         <= 1'b0;
      end else begin
         state      <= state_n;
         mem_addr   <= addr_n;
         mem_wdata  <= wdata_n;
         mem_we     <= we_n;
         busy       <= busy_n;
         done       <= done_n;
         fail       <= fail_n;
         fail_addr  <= fail_addr_n;
         fail_phase <= fail_phase_n;
         err_count  <= err_n;
         pv         <= pv_n;
         pa         <= pa_n;
         pp         <= pp_n;
      end
   end

   always_comb begin
      state_n      = state;
      addr_n       = mem_addr;
      wdata_n      = mem_wdata;
      we_n         = mem_we;
      busy_n       = busy;
      done_n       = done;
      fail_n       = fail;
      fail_addr_n  = fail_addr;
      fail_phase_n = fail_phase;
      err_n        = err_count;
      pv_n         = 1'b0;
      pa_n         = pa;
      pp_n         = pp;

      if (mism) begin
         if (err_count != 5'd31)
            err_n = err_count + 5'd1;
         fail_n = 1'b1;
         if (!fail) begin
            fail_addr_n  = pa;
            fail_phase_n = pp;
         end
      end

      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               state_n      = W0;
               addr_n       = '0;
               we_n         = 1'b1;
               wdata_n      = PATTERN;
               busy_n       = 1'b1;
               done_n       = 1'b0;
               fail_n       = 1'b0;
               fail_addr_n  = '0;
               fail_phase_n = 1'b0;
               err_n        = '0;
            end
         end
         W0: begin
            if (mem_addr == TOP) begin
               state_n = R0;
               addr_n  = '0;
               we_n    = 1'b0;
            end else begin
               addr_n = mem_addr + 1'b1;
            end
         end
         R0: begin
            pv_n = 1'b1;
            pa_n = mem_addr;
            pp_n = 1'b0;
            if (mem_addr == TOP)
               state_n = R0_DRAIN;
            else
               addr_n = mem_addr + 1'b1;
         end
         R0_DRAIN: begin
            state_n = W1;
            addr_n  = TOP;
            we_n    = 1'b1;
            wdata_n = ~PATTERN;
         end
         W1: begin
            if (mem_addr == BOT) begin
               state_n = R1;
               addr_n  = TOP;
               we_n    = 1'b0;
            end else begin
               addr_n = mem_addr - 1'b1;
            end
         end
         R1: begin
            pv_n = 1'b1;
            pa_n = mem_addr;
            pp_n = 1'b1;
            if (mem_addr == BOT)
               state_n = R1_DRAIN;
            else
               addr_n = mem_addr - 1'b1;
         end
         R1_DRAIN: begin
            state_n = DONE;
            addr_n  = '0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

`ifdef MEM_BIST_STOP_ON_FAIL_EN
      if (mism) begin
         state_n = DONE;
         addr_n  = '0;
         we_n    = 1'b0;
         wdata_n = mem_wdata;
         busy_n  = 1'b0;
         done_n  = 1'b1;
         pv_n    = 1'b0;
      end
`else
`endif
   end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: faulty RAM model plus run-level reference.
// Honours MEM_BIST_STOP_ON_FAIL_EN when computing expectations.
module tb_mem_bist_ctrl;

   localparam logic [15:0] PAT = 16'hA5A5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_we;
   logic [15:0] mem_rdata = '0;
   logic        busy;
   logic        done;
   logic        fail;
   logic [3:0]  fail_addr;
   logic        fail_phase;
   logic [4:0]  err_count;

   logic [15:0] mem  [16];
   logic [15:0] andm [16];
   logic [15:0] orm  [16];

   int total = 0;
   int bad   = 0;

   mem_bist_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_rdata  (mem_rdata),
      .busy       (busy),
      .done       (done),
      .fail       (fail),
      .fail_addr  (fail_addr),
      .fail_phase (fail_phase),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (mem_we) mem[mem_addr] <= mem_wdata;

   always @(posedge clk)
      mem_rdata <= (mem[mem_addr] & andm[mem_addr]) | orm[mem_addr];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic clear_faults();
      for (int a = 0; a < 16; a++) begin
         andm[a] = 16'hFFFF;
         orm[a]  = 16'h0000;
      end
   endtask

   // Expected port activity for cycle c of an uninterrupted run.
   task automatic sched(input int c, output logic we,
                        output logic [3:0] ad, output logic [15:0] wd);
      we = 1'b0; ad = 4'd0; wd = PAT;
      if (c <= 16) begin
         we = 1'b1; ad = 4'(c - 1);
      end else if (c <= 32) begin
         ad = 4'(c - 17);
      end else if (c == 33) begin
         ad = 4'd15;
      end else if (c <= 49) begin
         we = 1'b1; ad = 4'(49 - c); wd = ~PAT;
      end else if (c <= 65) begin
         ad = 4'(65 - c); wd = ~PAT;
      end else begin
         wd = ~PAT;
      end
   endtask

   task automatic run(input bit lvl, input int repulse, input int rst_at);
      int cnt = 0;
      int first_e = 0;
      int stop_e = 66;
      int last;
      logic [3:0]  fa = '0;
      logic        fp = 1'b0;
      logic [15:0] v;
      logic        e_we;
      logic [3:0]  e_ad;
      logic [15:0] e_wd;
      logic [4:0]  e_err;

      for (int a = 0; a < 16; a++) begin
         v = (PAT & andm[a]) | orm[a];
         if (v != PAT) begin
            if (cnt == 0) begin fa = 4'(a); fp = 1'b0; first_e = 18 + a; end
            cnt++;
         end
      end
      for (int a = 15; a >= 0; a--) begin
         v = (~PAT & andm[a]) | orm[a];
         if (v != ~PAT) begin
            if (cnt == 0) begin fa = 4'(a); fp = 1'b1; first_e = 66 - a; end
            cnt++;
         end
      end
`ifdef MEM_BIST_STOP_ON_FAIL_EN
      if (cnt > 0) begin stop_e = first_e; cnt = 1; end
`else
`endif
      e_err = (cnt > 31) ? 5'd31 : 5'(cnt);
      last  = stop_e + 1;

      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 if (!lvl) start = 1'b0;

      for (int c = 1; c <= last; c++) begin
         @(negedge clk);
         if (c == rst_at) begin
            rst = 1'b1; start = 1'b0;
            #1;
            chk("rst_mid", 32'({mem_addr, mem_wdata, mem_we, busy, done,
                fail, fail_addr, fail_phase, err_count}), 32'd0);
            #1 rst = 1'b0;
            return;
         end
         if (!lvl && c == repulse) start = 1'b1;
         if (!lvl && c == repulse + 1) start = 1'b0;
         if (c == last) begin
            start = 1'b0;
            e_we = 1'b0; e_ad = 4'd0;
            e_wd = (stop_e <= 33) ? PAT : ~PAT;
            chk($sformatf("cyc%0d", c),
                32'({busy, done, mem_we, mem_addr, mem_wdata}),
                32'({1'b0, 1'b1, e_we, e_ad, e_wd}));
            chk("fail", 32'(fail), 32'(cnt > 0));
            chk("fail_addr", 32'(fail_addr), 32'(fa));
            chk("fail_phase", 32'(fail_phase), 32'(fp));
            chk("err_count", 32'(err_count), 32'(e_err));
         end else begin
            sched(c, e_we, e_ad, e_wd);
            chk($sformatf("cyc%0d", c),
                32'({busy, done, mem_we, mem_addr, mem_wdata}),
                32'({1'b1, 1'b0, e_we, e_ad, e_wd}));
         end
      end
      repeat (2) @(negedge clk);
      chk("done_hold", 32'({busy, done, mem_we}), 32'({1'b0, 1'b1, 1'b0}));
   endtask

   initial begin
      for (int a = 0; a < 16; a++) mem[a] = 16'(a * 16'h1111);
      clear_faults();
      repeat (3) @(negedge clk);
      chk("rst_state", 32'({mem_addr, mem_wdata, mem_we, busy, done,
          fail, fail_addr, fail_phase, err_count}), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run(1'b0, 0, 0);

      clear_faults(); orm[5] = 16'h0001;
      run(1'b0, 0, 0);

      clear_faults(); andm[3] = 16'h7FFF;
      run(1'b0, 0, 0);

      for (int a = 0; a < 16; a++) andm[a] = 16'h0000;
      run(1'b0, 0, 0);

      clear_faults();
      run(1'b0, 10, 0);
      run(1'b0, 0, 40);
      run(1'b0, 0, 0);
      run(1'b1, 0, 0);

      for (int t = 0; t < 8; t++) begin
         int nf;
         int a;
         int b;
         clear_faults();
         nf = $urandom_range(3);
         for (int k = 0; k < nf; k++) begin
            a = $urandom_range(15);
            b = $urandom_range(15);
            if ($urandom_range(1) == 1) orm[a][b] = 1'b1;
            else andm[a][b] = 1'b0;
         end
         run(1'($urandom_range(1)), 0, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_bist_ctrl.md
Name: mem_bist_ctrl

Overview:
- Built-in self-test initiator for the 16x16 single-port RAM block. It drives the RAM's address, write-data and write-enable inputs and checks the RAM's read data.
- Runs a fixed four-phase march on start: W0 writes PATTERN in ascending order, R0 reads and checks PATTERN in ascending order, W1 writes ~PATTERN in descending order, R1 reads and checks ~PATTERN in descending order.
- Reports pass/fail, the first failing address and phase, and an error count. Sits between system control and the RAM, muxed ahead of the functional RAM port.

Parameters:
- DW, 16, data width; equals RAM word width.
- AW, 4, address width; depth = 2**AW.
- PATTERN, 16'hA5A5, background written in W0; W1 writes its bitwise inverse.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  pulse or level; sampled only in IDLE or DONE.
- mem_addr  output  AW  RAM address.
- mem_wdata  output  DW  RAM write data.
- mem_we  output  1  RAM write enable. The RAM writes on the falling edge of the same cycle.
- mem_rdata  input  DW  RAM registered read data. It reflects the address presented in the previous cycle.
- busy  output  1  high from the cycle after start is accepted until DONE is reached.
- done  output  1  level; high in DONE until the next start is accepted or rst.
- fail  output  1  sticky; high once any mismatch has been seen in the current run.
- fail_addr  output  AW  address of the first mismatch; 0 if none.
- fail_phase  output  1  phase of the first mismatch: 0 = R0, 1 = R1.
- err_count  output  5  number of mismatches; saturates at 31.

Behaviour:
- Reset state: state IDLE, and every output 0 (mem_addr, mem_wdata, mem_we, busy, done, fail, fail_addr, fail_phase, err_count).
- rst has immediate effect mid-run; any in-flight read check is discarded.
- States: IDLE, W0, R0, R0_DRAIN, W1, R1, R1_DRAIN, DONE.
- Start acceptance:
  - In IDLE or DONE, start=1 at edge E0 moves the block to W0.
  - On acceptance: fail, fail_addr, fail_phase, err_count and done clear; busy=1; mem_addr=0.
  - start is ignored in every other state.
- Cycle numbering: cycle n ends at edge En.
- W0 (cycles 1-16):
  - mem_we=1, mem_wdata=PATTERN.
  - mem_addr increments 0 to 15, one address per cycle.
- R0 (cycles 17-32):
  - mem_we=0; mem_addr issues 0 to 15.
  - A one-cycle delayed valid/address pipe compares mem_rdata against PATTERN at the edge ending the following cycle. The check for address 0 happens at E18.
- R0_DRAIN (cycle 33):
  - mem_addr holds 15, mem_we=0.
  - The last compare for address 15 happens at E33.
- W1 (cycles 34-49):
  - mem_we=1, mem_wdata=~PATTERN.
  - mem_addr decrements 15 to 0.
- R1 (cycles 50-65): mem_addr issues 15 to 0 and checks against ~PATTERN.
- R1_DRAIN (cycle 66): mem_addr holds 0; final compare for address 0 at E66.
- DONE (from E66):
  - busy=0 and done=1 in cycle 67.
  - mem_we=0, mem_addr=0.
  - Results hold until the next start.
- Total run: 66 cycles of busy.
- Mismatch handling, applied on every mismatch:
  - err_count increments, saturating at 31.
  - fail is set.
  - fail_addr and fail_phase are captured only when fail was previously 0.
- Address wrap: counters never wrap within a phase. The phase changes exactly at the terminal address: 15 for ascending phases, 0 for descending phases.
- mem_we is never high outside W0 and W1. mem_wdata holds its last value when mem_we=0.

Optional Feature:
- Macro: MEM_BIST_STOP_ON_FAIL_EN.
- Defined: on the first mismatch, the FSM goes directly to DONE on the same edge.
  - done=1 and busy=0 in the next cycle.
  - err_count=1.
  - The remaining in-flight compare is discarded.
- Undefined: the run always completes all phases, counting every mismatch.

Test Plan:
- Fault-free RAM model, PATTERN=A5A5, start pulse at E0 -> writes 0xA5A5 to addresses 0-15 during cycles 1-16, then 0x5A5A during cycles 34-49 descending; busy=1 for cycles 1-66; done=1 at cycle 67; fail=0, err_count=0.
- RAM bit0 of address 5 stuck at 1 -> R0 passes; R1 reads 0x5A5B at address 5 -> fail=1, fail_addr=5, fail_phase=1, err_count=1, done at cycle 67.
- RAM bit15 of address 3 stuck at 0, macro undefined -> R0 mismatch at E21 -> fail_addr=3, fail_phase=0, err_count=1, full run with done at cycle 67. With the macro defined -> done=1 at cycle 22, busy=0, err_count=1.
- All words stuck at 0x0000 -> 32 mismatches -> err_count saturates at 31, fail_addr=0, fail_phase=0.
- start re-pulsed at cycle 10 while busy -> ignored, run timing unchanged. rst=1 asynchronously at cycle 40 -> all outputs 0 immediately, state IDLE; a new start then produces a clean 66-cycle run.
